serial_parity_framer: RTL and testbench
=======================================

Name: serial_parity_framer

Overview:
- Parametrised successor to the single-bit serial parity generator.
- Accepts a serial bit stream under a valid/ready handshake and groups it into frames of DATA_BITS bits.
- Generate mode: forwards the data bits and inserts a parity bit after each frame.
- Check mode: consumes DATA_BITS data bits plus one received parity bit per frame, and flags any mismatch.
- Even/odd selectable per frame. Sits between a serialiser and a line driver/receiver in the serial datapath.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 1..255.
CNT_W, 8, counter width; must satisfy 2^CNT_W > DATA_BITS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
x  input  1  serial input bit
x_valid  input  1  x is valid this cycle
x_ready  output  1  block accepts x this cycle; transfer = x_valid & x_ready
odd_sel  input  1  0 = even parity, 1 = odd parity; latched at frame start
mode_check  input  1  0 = generate, 1 = check; latched at frame start
z  output  1  running parity of the current frame: XOR of accepted data bits XOR latched odd flag
y  output  1  serial output bit
y_valid  output  1  y is valid (one bit per asserted cycle, no backpressure)
frame_done  output  1  one-cycle pulse at end of frame
parity_err  output  1  one-cycle pulse with frame_done in check mode on mismatch

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- All outputs are registered. Reset values: z=0, y=0, y_valid=0, frame_done=0, parity_err=0, x_ready=1. Reset state is DATA, count=0.
- State machine states:
  - DATA: accepting bits; x_ready=1.
  - INSERT: generate mode only; x_ready=0.
- Frame start (transfer with count==0):
  - Latch odd_sel and mode_check.
  - Mid-frame changes on either input are ignored.
  - z seeds to odd_sel XOR x.
- Data transfer at cycle t (count < DATA_BITS):
  - At t+1: y=x, y_valid=1.
  - z updated to z XOR x (the seed applies on the first bit); count increments.
- Generate mode:
  - Transfer with count==DATA_BITS-1 at t moves the state to INSERT at t+1 (x_ready=0; y carries the last data bit).
  - At t+2: y=final z, y_valid=1, frame_done=1, parity_err=0. State returns to DATA, count=0, x_ready=1, z=0.
  - Throughput: DATA_BITS bits per DATA_BITS+1 cycles.
- Check mode:
  - x_ready stays at 1; there is no INSERT state.
  - The transfer with count==DATA_BITS is the parity bit.
  - At t+1: y_valid=0, frame_done=1, parity_err = (x != z). Then count=0, z=0.
- Idle cycles: x_valid=0 in DATA gives no transfer. The next cycle has y_valid=0, and count/z are held. Gaps are legal anywhere in a frame.
- y_valid, frame_done and parity_err are single-cycle pulses; they clear to 0 on any cycle without a new event.
- DATA_BITS=1: every data bit is its own frame. In generate mode the block alternates DATA/INSERT.
- Reset mid-frame: the partial frame is discarded with no frame_done or parity_err, and the block returns to reset values on the next edge.
- count never exceeds DATA_BITS; it wraps to 0 only at end of frame.

Optional Feature:
- Macro: SERIAL_PARITY_STICKY_ERR_EN.
- When defined:
  - Adds input err_clr (1 bit) and output err_sticky (1 bit).
  - err_sticky sets on the cycle after any parity_err pulse and holds until rst or err_clr.
  - If err_clr and a new error coincide, set wins.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Generate, even, DATA_BITS=8, bits 1,0,1,1,0,0,0,0 back-to-back:
  - y streams the same bits, then parity y=1 with frame_done=1.
  - x_ready=0 exactly one cycle before that parity output.
- Same stream with odd_sel=1: parity y=0. Toggle odd_sel mid-frame; the result is unchanged.
- Check, even, bits 1,0,1,1,0,0,0,0 then parity 1: frame_done=1, parity_err=0. Repeat with parity 0: frame_done=1, parity_err=1.
- Generate with x_valid gaps (pattern 1,0,1,0 per cycle) over one frame:
  - count/z hold during gaps; y_valid low in gap+1 cycles.
  - Final parity matches the gap-free run.
- Assert rst after 5 of 8 bits:
  - No frame_done; outputs at reset values.
  - The next full frame 1,1,1,1,1,1,1,1 (even) yields parity 0.
- DATA_BITS=1, generate, even, inputs 1,0: outputs 1,1 then 0,0, with frame_done on each parity bit. With SERIAL_PARITY_STICKY_ERR_EN defined, one check-mode error sets err_sticky until err_clr.

Source files
------------

// File: rtl/serial_parity_framer.sv
// Serial parity framer: groups a valid/ready bit stream into DATA_BITS-bit frames and either
// appends a parity bit (generate) or verifies a received one (check). Option: SERIAL_PARITY_STICKY_ERR_EN.

// state  | meaning
// DATA   | accepting serial bits (data bits, or the parity bit in check mode); x_ready=1
// INSERT | generate mode only: emitting the parity bit after the last data bit; x_ready=0
module serial_parity_framer #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic x_valid,
    output logic x_ready,
    input  logic odd_sel,
    input  logic mode_check,
`ifdef SERIAL_PARITY_STICKY_ERR_EN
    input  logic err_clr,
    output logic err_sticky,
`endif
    output logic z,
    output logic y,
    output logic y_valid,
    output logic frame_done,
    output logic parity_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_INSERT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             mode_q, mode_nxt;
    logic             z_nxt, y_nxt, y_valid_nxt, frame_done_nxt, parity_err_nxt;
    logic             xfer, frame_start, mode_eff, z_base;

    // The odd flag lives in z itself: it is folded into the seed at frame start, so only
    // the mode needs its own latch.
    always_comb begin
        xfer           = x_valid & x_ready;
        frame_start    = (count == '0);
        mode_eff       = frame_start ? mode_check : mode_q;
        z_base         = frame_start ? odd_sel : z;

        state_nxt      = state;
        count_nxt      = count;
        mode_nxt       = mode_q;
        z_nxt          = z;
        y_nxt          = y;
        y_valid_nxt    = 1'b0;
        frame_done_nxt = 1'b0;
        parity_err_nxt = 1'b0;

        case (state)
            ST_DATA: begin
                if (xfer) begin
                    if (frame_start) begin
                        mode_nxt = mode_check;
                    end
                    if (mode_eff && (count == CNT_FULL)) begin
                        frame_done_nxt = 1'b1;
                        parity_err_nxt = x ^ z;
                        count_nxt      = '0;
                        z_nxt          = 1'b0;
                    end else begin
                        y_nxt       = x;
                        y_valid_nxt = 1'b1;
                        z_nxt       = z_base ^ x;
                        count_nxt   = count + CNT_W'(1);
                        if (!mode_eff && (count == CNT_LAST)) begin
                            state_nxt = ST_INSERT;
                        end
                    end
                end
            end
            ST_INSERT: begin
                y_nxt          = z;
                y_valid_nxt    = 1'b1;
                frame_done_nxt = 1'b1;
                count_nxt      = '0;
                z_nxt          = 1'b0;
                state_nxt      = ST_DATA;
            end
            default: begin
                state_nxt = ST_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_DATA;
            count      <= '0;
            mode_q     <= 1'b0;
            z          <= 1'b0;
            y          <= 1'b0;
            y_valid    <= 1'b0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            x_ready    <= 1'b1;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            mode_q     <= mode_nxt;
            z          <= z_nxt;
            y          <= y_nxt;
            y_valid    <= y_valid_nxt;
            frame_done <= frame_done_nxt;
            parity_err <= parity_err_nxt;
            x_ready    <= (state_nxt == ST_DATA);
        end
    end

`ifdef SERIAL_PARITY_STICKY_ERR_EN
    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (parity_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_framer.sv
// Bench for serial_parity_framer: directed test-plan steps followed by random traffic, all checked
// against a frame-level reference model; two instances (DATA_BITS=8 and DATA_BITS=1).
`timescale 1ns/1ps
module tb_serial_parity_framer;

    logic clk = 1'b0;
    logic rst, odd_sel, mode_check, err_clr;
    logic x_a, xv_a, x_b, xv_b;
    logic xr_a, z_a, y_a, yv_a, fd_a, pe_a;
    logic xr_b, z_b, y_b, yv_b, fd_b, pe_b;
`ifdef SERIAL_PARITY_STICKY_ERR_EN
    logic stk_a, stk_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_parity_framer #(.DATA_BITS(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .x(x_a), .x_valid(xv_a), .x_ready(xr_a),
        .odd_sel(odd_sel), .mode_check(mode_check),
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        .err_clr(err_clr), .err_sticky(stk_a),
`endif
        .z(z_a), .y(y_a), .y_valid(yv_a), .frame_done(fd_a), .parity_err(pe_a)
    );

    serial_parity_framer #(.DATA_BITS(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .x(x_b), .x_valid(xv_b), .x_ready(xr_b),
        .odd_sel(odd_sel), .mode_check(mode_check),
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        .err_clr(err_clr), .err_sticky(stk_b),
`endif
        .z(z_b), .y(y_b), .y_valid(yv_b), .frame_done(fd_b), .parity_err(pe_b)
    );

    // Reference model: per instance, the number of data bits taken this frame, their count of ones,
    // the latched odd/mode flags and whether a parity insertion is owed.
    int nbits[2] = '{8, 1};
    int nb[2];
    int ones[2];
    bit od_l[2], mo_l[2], pend[2];
    bit ey[2], eyv[2], efd[2], epe[2], exr[2], ez[2], estk[2], chk_y[2];

    function automatic void model_step(int i, bit xi, bit xvi);
        bit stk_n, pe_n, par;
        if (rst) begin
            nb[i] = 0; ones[i] = 0; pend[i] = 0;
            ey[i] = 0; eyv[i] = 0; efd[i] = 0; epe[i] = 0;
            exr[i] = 1; ez[i] = 0; estk[i] = 0; chk_y[i] = 1;
            return;
        end
        stk_n  = epe[i] | (!err_clr & estk[i]);
        pe_n   = 0;
        eyv[i] = 0;
        efd[i] = 0;
        par    = od_l[i] ^ ((ones[i] % 2) != 0);
        if (pend[i]) begin
            ey[i] = par; eyv[i] = 1; efd[i] = 1;
            nb[i] = 0; ones[i] = 0; pend[i] = 0;
        end else if (xvi && exr[i]) begin
            if (nb[i] == 0) begin
                od_l[i] = odd_sel; mo_l[i] = mode_check; par = odd_sel;
            end
            if (mo_l[i] && nb[i] == nbits[i]) begin
                efd[i] = 1; pe_n = (xi != par);
                nb[i] = 0; ones[i] = 0;
            end else begin
                ones[i] += int'(xi); nb[i]++;
                ey[i] = xi; eyv[i] = 1;
                if (!mo_l[i] && nb[i] == nbits[i]) pend[i] = 1;
            end
        end
        epe[i]   = pe_n;
        estk[i]  = stk_n;
        exr[i]   = !pend[i];
        ez[i]    = (nb[i] == 0) ? 1'b0 : (od_l[i] ^ ((ones[i] % 2) != 0));
        chk_y[i] = eyv[i];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        model_step(0, x_a, xv_a);
        model_step(1, x_b, xv_b);
        @(posedge clk);
        #1;
        chk("a.x_ready", xr_a, exr[0]);
        chk("a.y_valid", yv_a, eyv[0]);
        chk("a.frame_done", fd_a, efd[0]);
        chk("a.parity_err", pe_a, epe[0]);
        chk("a.z", z_a, ez[0]);
        if (chk_y[0]) chk("a.y", y_a, ey[0]);
        chk("b.x_ready", xr_b, exr[1]);
        chk("b.y_valid", yv_b, eyv[1]);
        chk("b.frame_done", fd_b, efd[1]);
        chk("b.parity_err", pe_b, epe[1]);
        chk("b.z", z_b, ez[1]);
        if (chk_y[1]) chk("b.y", y_b, ey[1]);
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        chk("a.err_sticky", stk_a, estk[0]);
        chk("b.err_sticky", stk_b, estk[1]);
`endif
    endtask

    task automatic send_a(input logic [7:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            x_a = bits[k]; xv_a = 1'b1;
            tick();
        end
        xv_a = 1'b0;
    endtask

    logic [7:0] pat;

    initial begin
        rst = 1'b1; odd_sel = 1'b0; mode_check = 1'b0; err_clr = 1'b0;
        x_a = 1'b0; xv_a = 1'b0; x_b = 1'b0; xv_b = 1'b0;
        pat = 8'b0000_1101;   // 1,0,1,1,0,0,0,0 sent LSB first
        tick();
        tick();
        chk("reset.x_ready", xr_a, 1'b1);
        chk("reset.y", y_a, 1'b0);
        rst = 1'b0;
        tick();

        // generate, even
        send_a(pat, 8);
        chk("gen_even.x_ready_low", xr_a, 1'b0);
        tick();
        chk("gen_even.par", y_a, 1'b1);
        chk("gen_even.fd", fd_a, 1'b1);

        // generate, odd, with odd_sel toggling after the first bit
        odd_sel = 1'b1;
        x_a = pat[0]; xv_a = 1'b1;
        tick();
        odd_sel = 1'b0;
        for (int k = 1; k < 8; k++) begin
            x_a = pat[k];
            odd_sel = ~odd_sel;
            tick();
        end
        xv_a = 1'b0;
        tick();
        chk("gen_odd.par", y_a, 1'b0);
        chk("gen_odd.fd", fd_a, 1'b1);
        odd_sel = 1'b0;

        // check, even: good parity then bad parity
        mode_check = 1'b1;
        send_a(pat, 8);
        x_a = 1'b1; xv_a = 1'b1;
        tick();
        chk("chk_good.fd", fd_a, 1'b1);
        chk("chk_good.pe", pe_a, 1'b0);
        send_a(pat, 8);
        x_a = 1'b0; xv_a = 1'b1;
        tick();
        chk("chk_bad.fd", fd_a, 1'b1);
        chk("chk_bad.pe", pe_a, 1'b1);
        xv_a = 1'b0;
        mode_check = 1'b0;
        tick();
`ifdef SERIAL_PARITY_STICKY_ERR_EN
        chk("sticky.set", stk_a, 1'b1);
        tick();
        chk("sticky.hold", stk_a, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("sticky.clr", stk_a, 1'b0);
`endif

        // generate with valid gaps 1,0,1,0...
        begin
            int k = 0;
            int cyc = 0;
            while (k < 8) begin
                xv_a = (cyc % 2 == 0);
                x_a  = pat[k];
                tick();
                if (cyc % 2 == 0) k++;
                cyc++;
            end
        end
        xv_a = 1'b0;
        tick();
        chk("gap.par", y_a, 1'b1);
        chk("gap.fd", fd_a, 1'b1);

        // reset after 5 of 8 bits, then all-ones frame
        send_a(pat, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid.fd", fd_a, 1'b0);
        chk("rst_mid.z", z_a, 1'b0);
        send_a(8'hFF, 8);
        tick();
        chk("ones.par", y_a, 1'b0);
        chk("ones.fd", fd_a, 1'b1);

        // DATA_BITS=1: inputs 1 then 0
        x_b = 1'b1; xv_b = 1'b1;
        tick();
        chk("b1.data", y_b, 1'b1);
        x_b = 1'b0;
        tick();
        chk("b1.par", y_b, 1'b1);
        chk("b1.fd", fd_b, 1'b1);
        tick();
        chk("b0.data", y_b, 1'b0);
        chk("b0.yv", yv_b, 1'b1);
        xv_b = 1'b0;
        tick();
        chk("b0.par", y_b, 1'b0);
        chk("b0.fd", fd_b, 1'b1);

        // random traffic on both instances
        for (int c = 0; c < 1500; c++) begin
            xv_a       = ($urandom_range(0, 3) != 0);
            x_a        = 1'($urandom_range(0, 1));
            xv_b       = ($urandom_range(0, 3) != 0);
            x_b        = 1'($urandom_range(0, 1));
            odd_sel    = 1'($urandom_range(0, 1));
            mode_check = 1'($urandom_range(0, 1));
            err_clr    = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
